// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

    // Sequencer states: normal issue, or the second cycle of exception entry.
    typedef enum logic [0:0] {
        RUN,
        EXC_DRAIN
    } state_e;

    // Register 0 is hard-wired to zero and never creates a dependency.
    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam int unsigned MDU_LATENCY_DEFAULT = 32;

endpackage

// File: rtl/mdu_busy_counter.sv
// Down-counter covering the mult/div busy window; loads the MDU latency on
// issue and saturates at zero.
module mdu_busy_counter
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MDU_LATENCY = MDU_LATENCY_DEFAULT,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    output logic             busy,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MDU_LATENCY);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: reload on issue, otherwise count down towards zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = LOAD_VAL;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign busy = (cnt_q != '0);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use and MDU stalls,
// branch/jump redirects and two-cycle exception entry.
// Optional build macro HAZ_PERF_CNT_EN adds stall/flush event counters.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MDU_LATENCY = MDU_LATENCY_DEFAULT,
    parameter int unsigned CNT_W       = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_rs_used,
    input  logic        id_rt_used,
    input  logic        ex_memread,
    input  logic [4:0]  ex_rt,
    input  logic        id_jump,
    input  logic        ex_branch_taken,
    input  logic        id_mdu_start,
    input  logic        id_mdu_read,
    input  logic        exc_req,
    output logic        pc_write,
    output logic        ifid_stall,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        exmem_flush,
    output logic        pc_sel_exc,
    output logic        mdu_busy
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_events
`endif
);

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] mdu_cnt;
    logic             mdu_load;
    logic             load_use;
    logic             mdu_wait;
    logic             stall;
    logic             redirect_flush;

    mdu_busy_counter #(
        .MDU_LATENCY(MDU_LATENCY),
        .CNT_W      (CNT_W)
    ) u_mdu_cnt (
        .clk  (clk),
        .reset(reset),
        .load (mdu_load),
        .busy (mdu_busy),
        .cnt  (mdu_cnt)
    );

    // Hazard decode for the instruction currently in ID.
    always_comb begin
        load_use = ex_memread && (ex_rt != REG_ZERO) &&
                   ((id_rs_used && (id_rs == ex_rt)) || (id_rt_used && (id_rt == ex_rt)));
        mdu_wait = id_mdu_read && (mdu_cnt != '0);
        stall    = load_use || mdu_wait;
        // Issue only when the mult/div really leaves ID on the right path.
        mdu_load = id_mdu_start && !stall && !exc_req && !ex_branch_taken && (state_q == RUN);
    end

    // Next state and pipeline control, highest-priority cause first.
    always_comb begin
        state_d        = state_q;
        pc_write       = 1'b0;
        ifid_stall     = 1'b0;
        ifid_flush     = 1'b0;
        idex_flush     = 1'b0;
        exmem_flush    = 1'b0;
        pc_sel_exc     = 1'b0;
        redirect_flush = 1'b0;
        if (reset) begin
            ifid_flush = 1'b1;
            state_d    = RUN;
        end else if (exc_req) begin
            ifid_flush     = 1'b1;
            idex_flush     = 1'b1;
            exmem_flush    = 1'b1;
            pc_sel_exc     = 1'b1;
            pc_write       = 1'b1;
            redirect_flush = 1'b1;
            state_d        = EXC_DRAIN;
        end else if (state_q == EXC_DRAIN) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            pc_write   = 1'b1;
            state_d    = RUN;
        end else if (ex_branch_taken) begin
            // The stalled ID instruction is on the wrong path, so the stall is moot.
            ifid_flush     = 1'b1;
            idex_flush     = 1'b1;
            pc_write       = 1'b1;
            redirect_flush = 1'b1;
        end else if (id_jump && !stall) begin
            ifid_flush = 1'b1;
            pc_write   = 1'b1;
        end else if (stall) begin
            // A jump held here is retried once the hazard clears.
            ifid_stall = 1'b1;
            idex_flush = 1'b1;
        end else begin
            pc_write = 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] flush_events_q;

    // Event counters; wrap naturally at 2^32.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles_q <= '0;
            flush_events_q <= '0;
        end else begin
            if (ifid_stall) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
            if (redirect_flush) begin
                flush_events_q <= flush_events_q + 32'd1;
            end
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_events = flush_events_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized and directed bench for pipeline_hazard_ctrl against a
// cycle-level behavioural model of the stall/flush rules.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned LAT = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       id_rs_used, id_rt_used, ex_memread, id_jump, ex_branch_taken;
    logic       id_mdu_start, id_mdu_read, exc_req;
    logic       pc_write, ifid_stall, ifid_flush, idex_flush, exmem_flush, pc_sel_exc;
    logic       mdu_busy;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cycles, flush_events;
`endif

    pipeline_hazard_ctrl #(
        .MDU_LATENCY(LAT),
        .CNT_W      (8)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_rs_used     (id_rs_used),
        .id_rt_used     (id_rt_used),
        .ex_memread     (ex_memread),
        .ex_rt          (ex_rt),
        .id_jump        (id_jump),
        .ex_branch_taken(ex_branch_taken),
        .id_mdu_start   (id_mdu_start),
        .id_mdu_read    (id_mdu_read),
        .exc_req        (exc_req),
        .pc_write       (pc_write),
        .ifid_stall     (ifid_stall),
        .ifid_flush     (ifid_flush),
        .idex_flush     (idex_flush),
        .exmem_flush    (exmem_flush),
        .pc_sel_exc     (pc_sel_exc),
        .mdu_busy       (mdu_busy)
`ifdef HAZ_PERF_CNT_EN
        ,
        .stall_cycles   (stall_cycles),
        .flush_events   (flush_events)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: cycles of MDU work left, whether the exception drain cycle is due,
    // and the two event counts.
    int          m_mdu_left;
    bit          m_drain;
    logic [31:0] m_stalls;
    logic [31:0] m_flushes;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_stall();
        bit lu;
        lu = ex_memread && (ex_rt != 0) &&
             ((id_rs_used && id_rs == ex_rt) || (id_rt_used && id_rt == ex_rt));
        return lu || (id_mdu_read && m_mdu_left > 0);
    endfunction

    // {pc_write, ifid_stall, ifid_flush, idex_flush, exmem_flush, pc_sel_exc, mdu_busy}
    function automatic logic [6:0] model_out();
        bit st;
        st = model_stall();
        if (reset)                return 7'b0010000;
        if (exc_req)              return {6'b101111, m_mdu_left > 0};
        if (m_drain)              return {6'b101100, m_mdu_left > 0};
        if (ex_branch_taken)      return {6'b101100, m_mdu_left > 0};
        if (id_jump && !st)       return {6'b101000, m_mdu_left > 0};
        if (st)                   return {6'b010100, m_mdu_left > 0};
        return {6'b100000, m_mdu_left > 0};
    endfunction

    task automatic model_reset();
        m_mdu_left = 0;
        m_drain    = 0;
        m_stalls   = '0;
        m_flushes  = '0;
    endtask

    task automatic observe();
        logic [6:0] exp;
        #1;
        if (reset) model_reset();
        exp = model_out();
        check_eq("ctrl", {pc_write, ifid_stall, ifid_flush, idex_flush, exmem_flush,
                          pc_sel_exc, mdu_busy}, {25'd0, exp});
`ifdef HAZ_PERF_CNT_EN
        check_eq("stall_cycles", stall_cycles, m_stalls);
        check_eq("flush_events", flush_events, m_flushes);
`endif
    endtask

    // Apply the clock edge to the model, then move to the next drive point.
    task automatic advance();
        logic [6:0] o;
        bit         st;
        o  = model_out();
        st = model_stall();
        if (reset) begin
            model_reset();
        end else begin
            if (o[5]) m_stalls = m_stalls + 1;
            if (exc_req || (!m_drain && ex_branch_taken)) m_flushes = m_flushes + 1;
            if (id_mdu_start && !st && !exc_req && !ex_branch_taken && !m_drain)
                m_mdu_left = LAT;
            else if (m_mdu_left > 0)
                m_mdu_left = m_mdu_left - 1;
            m_drain = exc_req;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        id_rs = 0; id_rt = 0; ex_rt = 0;
        id_rs_used = 0; id_rt_used = 0; ex_memread = 0; id_jump = 0;
        ex_branch_taken = 0; id_mdu_start = 0; id_mdu_read = 0; exc_req = 0;
    endtask

    task automatic set_load_use();
        ex_memread = 1; ex_rt = 5'd8; id_rs = 5'd8; id_rs_used = 1;
    endtask

    initial begin
        int busy_n;
        reset = 1;
        idle_inputs();
        model_reset();
        @(negedge clk);
        observe();
        check_eq("reset_ifid_flush", {31'd0, ifid_flush}, 32'd1);
        advance();
        reset = 0;

        // Load-use stall, then same pattern on register 0.
        set_load_use();
        observe();
        check_eq("lu_stall", {29'd0, pc_write, ifid_stall, idex_flush}, 32'b011);
        advance();
        ex_rt = 0; id_rs = 0;
        observe();
        check_eq("lu_r0_nostall", {31'd0, ifid_stall}, 32'd0);
        advance();

        // Branch overrides the stall.
        idle_inputs(); set_load_use(); ex_branch_taken = 1;
        observe();
        check_eq("br_over_stall", {28'd0, ifid_flush, idex_flush, pc_write, ifid_stall},
                 32'b1110);
        advance();

        // Jump held by a stall, taken the next cycle.
        idle_inputs(); set_load_use(); id_jump = 1;
        observe();
        check_eq("jump_held", {31'd0, ifid_flush}, 32'd0);
        advance();
        ex_memread = 0;
        observe();
        check_eq("jump_taken", {30'd0, ifid_flush, pc_write}, 32'b11);
        advance();

        // Exception entry over two cycles.
        idle_inputs(); exc_req = 1;
        observe();
        check_eq("exc_c0", {27'd0, ifid_flush, idex_flush, exmem_flush, pc_sel_exc, pc_write},
                 32'b11111);
        advance();
        exc_req = 0;
        observe();
        check_eq("exc_c1", {30'd0, ifid_flush, pc_sel_exc}, 32'b10);
        advance();
        observe();
        check_eq("exc_c2", {29'd0, pc_write, ifid_flush, idex_flush}, 32'b100);
        advance();

        // MDU busy window with a waiting read.
        idle_inputs(); id_mdu_start = 1;
        observe();
        advance();
        id_mdu_start = 0; id_mdu_read = 1;
        busy_n = 0;
        for (int i = 0; i < 8; i++) begin
            observe();
            if (mdu_busy) busy_n++;
            check_eq("mdu_stall_tracks_busy", {31'd0, ifid_stall}, {31'd0, mdu_busy});
            advance();
        end
        check_eq("mdu_busy_len", busy_n, LAT);

        // Async reset in the middle of an MDU operation (count at 2).
        idle_inputs(); id_mdu_start = 1;
        observe();
        advance();
        id_mdu_start = 0;
        observe(); advance();
        observe(); advance();
        check_eq("mdu_mid_busy", {31'd0, mdu_busy}, 32'd1);
        reset = 1;
        observe();
        check_eq("rst_mid_busy", {30'd0, mdu_busy, ifid_flush}, 32'b01);
        advance();
        reset = 0; id_mdu_read = 1;
        observe();
        check_eq("post_rst_read", {31'd0, ifid_stall}, 32'd0);
        advance();

        // Randomized traffic with occasional asynchronous resets.
        for (int i = 0; i < 600; i++) begin
            id_rs           = 5'($urandom_range(0, 3));
            id_rt           = 5'($urandom_range(0, 3));
            ex_rt           = 5'($urandom_range(0, 3));
            id_rs_used      = 1'($urandom_range(0, 1));
            id_rt_used      = 1'($urandom_range(0, 1));
            ex_memread      = ($urandom_range(0, 2) == 0);
            id_jump         = ($urandom_range(0, 5) == 0);
            ex_branch_taken = ($urandom_range(0, 7) == 0);
            id_mdu_start    = ($urandom_range(0, 5) == 0);
            id_mdu_read     = ($urandom_range(0, 3) == 0);
            exc_req         = ($urandom_range(0, 11) == 0);
            reset           = ($urandom_range(0, 59) == 0);
            observe();
            advance();
        end
        reset = 0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage MIPS pipeline. It drives the stall and flush inputs of the IF/ID register, the flush inputs of the ID/EX and EX/MEM registers, and PC write-enable. It detects load-use hazards, resolves jump and branch redirects, and tracks the multi-cycle mult/div unit (MDU) busy window. It sequences exception entry as a two-cycle flush.

Parameters:
MDU_LATENCY, 32, cycles from MDU issue until HI/LO are valid (legal range 2..255).
CNT_W, 8, width of the MDU busy counter; must satisfy 2^CNT_W > MDU_LATENCY.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-high.
id_rs  in  5  rs field of the instruction in ID.
id_rt  in  5  rt field of the instruction in ID.
id_rs_used  in  1  ID instruction reads rs.
id_rt_used  in  1  ID instruction reads rt.
ex_memread  in  1  instruction in EX is a load.
ex_rt  in  5  destination register of the load in EX.
id_jump  in  1  j/jal/jr resolved in ID.
ex_branch_taken  in  1  branch resolved taken in EX.
id_mdu_start  in  1  mult/div in ID (issues this cycle if not stalled).
id_mdu_read  in  1  mfhi/mflo/mthi/mtlo/mult/div in ID that needs the MDU idle.
exc_req  in  1  exception or interrupt signalled from MEM.
pc_write  out  1  PC register update enable.
ifid_stall  out  1  hold IF/ID contents.
ifid_flush  out  1  zero the IF/ID instruction.
idex_flush  out  1  insert a bubble into ID/EX.
exmem_flush  out  1  insert a bubble into EX/MEM.
pc_sel_exc  out  1  select the exception vector for the next PC.
mdu_busy  out  1  MDU counter non-zero.

Behaviour:
- Outputs are combinational from the registered state, the registered counter and the current inputs. Registered state: FSM state and mdu_cnt.
- FSM states: RUN, EXC_DRAIN.
- While reset is high:
  - state=RUN, mdu_cnt=0.
  - Outputs forced to pc_write=0, ifid_flush=1; all other outputs 0.
- Hazard terms (register 0 never causes a hazard):
  - load_use = ex_memread & (ex_rt!=0) & ((id_rs_used & id_rs==ex_rt) | (id_rt_used & id_rt==ex_rt)).
  - mdu_wait = id_mdu_read & (mdu_cnt!=0).
  - stall = load_use | mdu_wait.
- Priority in RUN (highest first):
  1. exc_req:
     - ifid_flush=1, idex_flush=1, exmem_flush=1, pc_sel_exc=1, pc_write=1.
     - Next state EXC_DRAIN. An MDU issue in the same cycle is cancelled.
  2. ex_branch_taken:
     - ifid_flush=1, idex_flush=1, pc_write=1.
     - Overrides stall; the stalled ID instruction is on the wrong path.
  3. id_jump & !stall:
     - ifid_flush=1, pc_write=1.
  4. stall:
     - pc_write=0, ifid_stall=1, idex_flush=1.
     - ifid_flush=0, even if id_jump is high (the jump retries next cycle).
  5. Otherwise: pc_write=1, all other outputs 0.
- EXC_DRAIN, one cycle:
  - ifid_flush=1, idex_flush=1, pc_write=1, pc_sel_exc=0.
  - Always returns to RUN.
  - A new exc_req in this cycle takes priority: same outputs as RUN case 1, and the state stays EXC_DRAIN.
- MDU counter:
  - Load: on a clock edge where id_mdu_start=1, no stall, no exc_req, no ex_branch_taken and state==RUN, mdu_cnt loads MDU_LATENCY.
  - Else, if mdu_cnt!=0, it decrements by 1.
  - An issue while busy is itself an id_mdu_read stall, so no reload occurs while non-zero.
  - mdu_busy = (mdu_cnt!=0). The counter saturates at 0.
  - exc_req does not clear an in-flight MDU operation.
- Reset asserted mid-operation clears the state and counter immediately. After deassertion the first clock edge behaves as RUN with mdu_cnt=0.

Optional Feature:
HAZ_PERF_CNT_EN.
- Defined: adds outputs stall_cycles[31:0] and flush_events[31:0], both cleared by reset and wrapping at 2^32.
  - stall_cycles increments every cycle in which ifid_stall=1.
  - flush_events increments every cycle in which idex_flush=1 caused by exc_req or ex_branch_taken.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - FSM state typedef {RUN, EXC_DRAIN}.
  - REG_ZERO=5'd0.
  - Default MDU_LATENCY.
- Sub-module mdu_busy_counter (parameters MDU_LATENCY, CNT_W): ports clk, reset, load, busy, cnt.
- FSM and hazard decode stay in the top module.

Test Plan:
- Load-use: ex_memread=1, ex_rt=8, id_rs=8, id_rs_used=1 -> one cycle of pc_write=0, ifid_stall=1, idex_flush=1. With ex_rt=0, no stall.
- Branch over stall: load_use and ex_branch_taken both high -> ifid_flush=1, idex_flush=1, pc_write=1, ifid_stall=0.
- MDU: id_mdu_start for one cycle with MDU_LATENCY=4, then id_mdu_read held high:
  - mdu_busy stays high 4 cycles.
  - ifid_stall is high while mdu_cnt!=0 and released when cnt=0.
- Exception: exc_req pulse -> cycle 0: all three flushes and pc_sel_exc=1; cycle 1: EXC_DRAIN, ifid_flush=1, pc_sel_exc=0; cycle 2: normal run.
- Jump during stall: id_jump=1 with load_use=1 -> no ifid_flush that cycle; next cycle (no hazard) ifid_flush=1, pc_write=1.
- Async reset asserted mid-MDU (cnt=2) between clock edges -> mdu_busy=0 and ifid_flush=1 immediately; after release, mdu_read proceeds without stall.
